// File: rtl/cp0_exception_sequencer.sv
// cp0_exception_sequencer: prioritises interrupt/exception/ERET, commits to CP0, flushes, redirects IF; owns Count/Compare.
// Ports: clock/reset (async active-low); wb_* WB-stage instruction info; hw_interrupt async lines;
// status_*/cause_ip_sw/epc current CP0 state; cp0_* one-cycle commit to CP0; cause_ip_hw/timer_interrupt
// interrupt sources; count_value/compare_value timer registers; pipeline_flush/redirect_*/wb_stall pipeline control.
module cp0_exception_sequencer #(
  parameter logic [31:0] EXCEPTION_VECTOR = 32'hBFC0_0380,
  parameter int HW_INT_WIDTH = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    wb_valid,
  input  logic [31:0]             wb_pc,
  input  logic                    wb_in_delay_slot,
  input  logic                    wb_exception,
  input  logic [4:0]              wb_exception_code,
  input  logic                    wb_eret,
  input  logic                    wb_mtc0,
  input  logic [7:0]              wb_cp0_address,
  input  logic [31:0]             wb_write_data,
  input  logic [HW_INT_WIDTH-1:0] hw_interrupt,
  input  logic                    status_ie,
  input  logic                    status_exl,
  input  logic [7:0]              status_im,
  input  logic [1:0]              cause_ip_sw,
  input  logic [31:0]             epc,
  output logic                    cp0_exception,
  output logic [4:0]              cp0_exception_code,
  output logic [31:0]             cp0_exception_address,
  output logic                    cp0_in_delay_slot,
  output logic                    cp0_eret,
  output logic [HW_INT_WIDTH-1:0] cause_ip_hw,
  output logic                    timer_interrupt,
  output logic [31:0]             count_value,
  output logic [31:0]             compare_value,
  output logic                    pipeline_flush,
  output logic                    redirect_valid,
  output logic [31:0]             redirect_pc,
  input  logic                    redirect_ready,
  output logic                    wb_stall
);
  typedef enum logic {IDLE, REDIRECT} state_t;
  state_t state, state_next;
  logic [HW_INT_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [HW_INT_WIDTH+1:0] ip_all;
  logic idle, int_pending, take_int, take_exc, take_eret, exc_commit, eret_commit, mtc0_en;
  logic count_wr, compare_wr, toggle;
  logic [31:0] count_inc;

  // Timer interrupt shares the top hardware line, as on classic MIPS32.
  assign cause_ip_hw = sync_q[SYNC_STAGES-1] | (HW_INT_WIDTH'(timer_interrupt) << (HW_INT_WIDTH-1));
  assign ip_all = {cause_ip_hw, cause_ip_sw};
  assign int_pending = status_ie & ~status_exl & |(status_im & 8'(ip_all));
  assign idle = state == IDLE;
  assign take_int = wb_valid & int_pending;
  assign take_exc = wb_valid & wb_exception & ~int_pending;
  assign take_eret = wb_valid & wb_eret & ~wb_exception & ~int_pending;
  assign exc_commit = idle & (take_int | take_exc);
  assign eret_commit = idle & take_eret;
  // An MTC0 that coincides with any selected event is the faulting instruction and must not write.
  assign mtc0_en = wb_valid & wb_mtc0 & idle & ~(take_int | take_exc | take_eret);
  assign count_wr = mtc0_en & (wb_cp0_address == {5'd9, 3'd0});
  assign compare_wr = mtc0_en & (wb_cp0_address == {5'd11, 3'd0});
  assign count_inc = count_value + 32'd1;
  assign redirect_valid = state == REDIRECT;
  assign wb_stall = state == REDIRECT;

  always_ff @(posedge clock or negedge reset)
    if (!reset) for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    else begin
      sync_q[0] <= hw_interrupt;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end

  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_next;

  always_comb begin
    state_next = state;
    if (idle) state_next = (exc_commit | eret_commit) ? REDIRECT : IDLE;
    else state_next = redirect_ready ? IDLE : REDIRECT;
  end

  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      cp0_exception <= 1'b0;
      cp0_eret <= 1'b0;
      pipeline_flush <= 1'b0;
      cp0_exception_code <= '0;
      cp0_exception_address <= '0;
      cp0_in_delay_slot <= 1'b0;
      redirect_pc <= '0;
    end else begin
      cp0_exception <= exc_commit;
      cp0_eret <= eret_commit;
      pipeline_flush <= exc_commit | eret_commit;
      if (exc_commit) begin
        cp0_exception_code <= take_int ? 5'd0 : wb_exception_code;
        cp0_exception_address <= wb_pc;
        cp0_in_delay_slot <= wb_in_delay_slot;
      end
      if (exc_commit | eret_commit) redirect_pc <= eret_commit ? epc : EXCEPTION_VECTOR;
    end

  // Count advances every other cycle; software writes take precedence over hardware updates.
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      toggle <= 1'b0;
      count_value <= '0;
      compare_value <= '0;
      timer_interrupt <= 1'b0;
    end else begin
      toggle <= ~count_wr & ~toggle;
      count_value <= count_wr ? wb_write_data : toggle ? count_inc : count_value;
      compare_value <= compare_wr ? wb_write_data : compare_value;
      timer_interrupt <= compare_wr ? 1'b0 : timer_interrupt | (toggle & ~count_wr & (count_inc == compare_value));
    end
endmodule
